// File: rtl/neuron_pkg.sv
// Shared FSM state type and default sizing for the time-multiplexed neuron scheduler.
package neuron_pkg;

  localparam int unsigned N_NEURONS     = 4;
  localparam int unsigned N_MEMBRANE    = 5;
  localparam int unsigned SPIKE_COUNT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/membrane_state_bank.sv
// Per-neuron membrane and spike-flag storage: one write port, one async read port,
// synchronous clear and asynchronous reset.
module membrane_state_bank #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   waddr,
  input  logic signed [WIDTH-1:0]    wr_membrane,
  input  logic                       wr_spike,
  input  logic [$clog2(DEPTH)-1:0]   raddr,
  output logic signed [WIDTH-1:0]    rd_membrane,
  output logic                       rd_spike
);
  import neuron_pkg::*;

  logic signed [WIDTH-1:0] membrane [DEPTH];
  logic [DEPTH-1:0]        spike;

  // Clear outranks a write landing on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) membrane[i] <= '0;
      spike <= '0;
    end else if (clear) begin
      for (int i = 0; i < int'(DEPTH); i++) membrane[i] <= '0;
      spike <= '0;
    end else if (we) begin
      membrane[waddr] <= wr_membrane;
      spike[waddr]    <= wr_spike;
    end
  end

  assign rd_membrane = membrane[raddr];
  assign rd_spike    = spike[raddr];

endmodule

// File: rtl/neuron_scheduler.sv
// Sweeps all neurons once per start, storing datapath results and publishing the spike vector.
// Optional NEURON_SPIKE_COUNT_EN adds a saturating 8-bit spike counter port.
module neuron_scheduler #(
  parameter int unsigned N_NEURONS  = neuron_pkg::N_NEURONS,
  parameter int unsigned N_MEMBRANE = neuron_pkg::N_MEMBRANE
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           clear,
  output logic [$clog2(N_NEURONS)-1:0]   neuron_idx,
  output logic signed [N_MEMBRANE-1:0]   last_membrane,
  output logic                           was_spike,
  input  logic signed [N_MEMBRANE-1:0]   new_membrane,
  input  logic                           is_spike,
  output logic [N_NEURONS-1:0]           spikes,
  output logic                           spikes_valid,
  output logic                           busy
`ifdef NEURON_SPIKE_COUNT_EN
  ,
  output logic [neuron_pkg::SPIKE_COUNT_W-1:0] spike_count
`endif
);
  import neuron_pkg::*;

  localparam int unsigned IDX_W = $clog2(N_NEURONS);

  state_t               state;
  logic [N_NEURONS-1:0] shadow;
  logic [N_NEURONS-1:0] shadow_next;
  logic                 last_idx;
  logic                 bank_we;

  assign last_idx = (neuron_idx == IDX_W'(N_NEURONS - 1));
  assign bank_we  = (state == EVAL);

  // Shadow with the current neuron's spike merged in, so the final edge publishes all bits.
  always_comb begin
    shadow_next             = shadow;
    shadow_next[neuron_idx] = is_spike;
  end

  membrane_state_bank #(
    .DEPTH (N_NEURONS),
    .WIDTH (N_MEMBRANE)
  ) u_bank (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (clear),
    .we          (bank_we),
    .waddr       (neuron_idx),
    .wr_membrane (new_membrane),
    .wr_spike    (is_spike),
    .raddr       (neuron_idx),
    .rd_membrane (last_membrane),
    .rd_spike    (was_spike)
  );

  // Sweep FSM; clear aborts any sweep but leaves the published spike vector intact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      neuron_idx   <= '0;
      shadow       <= '0;
      spikes       <= '0;
      spikes_valid <= 1'b0;
      busy         <= 1'b0;
    end else if (clear) begin
      state        <= IDLE;
      neuron_idx   <= '0;
      shadow       <= '0;
      spikes_valid <= 1'b0;
      busy         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          spikes_valid <= 1'b0;
          neuron_idx   <= '0;
          if (start) begin
            state  <= EVAL;
            busy   <= 1'b1;
            shadow <= '0;
          end
        end
        EVAL: begin
          shadow <= shadow_next;
          if (last_idx) begin
            state        <= DONE;
            neuron_idx   <= '0;
            spikes       <= shadow_next;
            spikes_valid <= 1'b1;
          end else begin
            neuron_idx <= neuron_idx + IDX_W'(1);
          end
        end
        DONE: begin
          state        <= IDLE;
          spikes_valid <= 1'b0;
          busy         <= 1'b0;
        end
        default: begin
          state        <= IDLE;
          neuron_idx   <= '0;
          spikes_valid <= 1'b0;
          busy         <= 1'b0;
        end
      endcase
    end
  end

`ifdef NEURON_SPIKE_COUNT_EN
  // Saturating count of spikes written during sweeps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spike_count <= '0;
    end else if (clear) begin
      spike_count <= '0;
    end else if ((state == EVAL) && is_spike && (spike_count != {SPIKE_COUNT_W{1'b1}})) begin
      spike_count <= spike_count + SPIKE_COUNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_neuron_scheduler.sv
// Directed bench for neuron_scheduler with a spike-vector scoreboard.
module tb_neuron_scheduler;

  localparam int unsigned N = 4;
  localparam int unsigned W = 5;

  logic                clk;
  logic                rst_n;
  logic                start;
  logic                clear;
  logic [1:0]          neuron_idx;
  logic signed [W-1:0] last_membrane;
  logic                was_spike;
  logic signed [W-1:0] new_membrane;
  logic                is_spike;
  logic [N-1:0]        spikes;
  logic                spikes_valid;
  logic                busy;
`ifdef NEURON_SPIKE_COUNT_EN
  logic [7:0]          spike_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int n_pushed = 0;
  int n_seen   = 0;
  int mode     = 0;

  logic [N-1:0] sb_q [$];
  int           model_mem [N];
  logic         model_spk [N];
  logic [N-1:0] last_spikes;

  neuron_scheduler #(
    .N_NEURONS  (N),
    .N_MEMBRANE (W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .clear         (clear),
    .neuron_idx    (neuron_idx),
    .last_membrane (last_membrane),
    .was_spike     (was_spike),
    .new_membrane  (new_membrane),
    .is_spike      (is_spike),
    .spikes        (spikes),
    .spikes_valid  (spikes_valid),
    .busy          (busy)
`ifdef NEURON_SPIKE_COUNT_EN
    ,
    .spike_count   (spike_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in neuron datapath: per-mode membrane and spike results by index.
  function automatic int dp_mem(input int m, input int i);
    case (m)
      0:       return i + 1;
      1:       return (i == 0) ? -16 : ((i == 1) ? 15 : 0);
      default: return -3 * (i + 1);
    endcase
  endfunction

  function automatic logic dp_spk(input int m, input int i);
    case (m)
      0:       return (i == 2);
      1:       return (i < 2);
      default: return (i == 0) || (i == 3);
    endcase
  endfunction

  always_comb begin
    new_membrane = W'(dp_mem(mode, int'(neuron_idx)));
    is_spike     = dp_spk(mode, int'(neuron_idx));
  end

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic zero_model();
    for (int i = 0; i < int'(N); i++) begin
      model_mem[i] = 0;
      model_spk[i] = 1'b0;
    end
  endtask

  // Scoreboard: every published spike vector must match the oldest pending expectation.
  always @(negedge clk) begin
    if (spikes_valid === 1'b1) begin
      n_seen++;
      n_checks++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $error("FAIL sb_unexpected: observed spikes %b with no pending sweep", spikes);
      end else begin
        logic [N-1:0] e;
        e = sb_q.pop_front();
        assert (spikes === e) else begin
          n_fail++;
          $error("FAIL sb_spikes: observed %b expected %b", spikes, e);
        end
      end
    end
  end

  // One full sweep; optionally pulses a second start while busy at index busy_start_at.
  task automatic do_sweep(input int m, input logic [N-1:0] exp_vec, input int busy_start_at);
    mode  = m;
    start = 1'b1;
    sb_q.push_back(exp_vec);
    n_pushed++;
    tick();
    start = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      check($sformatf("idx%0d", i), neuron_idx, i);
      check($sformatf("busy_eval%0d", i), busy, 1);
      check($sformatf("valid_eval%0d", i), spikes_valid, 0);
      check($sformatf("rd_mem%0d", i), last_membrane, model_mem[i]);
      check($sformatf("rd_spk%0d", i), was_spike, model_spk[i]);
      if (i == busy_start_at) start = 1'b1;
      tick();
      start = 1'b0;
    end
    check("valid_done", spikes_valid, 1);
    check("busy_done", busy, 1);
    check("idx_done", neuron_idx, 0);
    check("spikes_done", spikes, exp_vec);
    tick();
    check("busy_idle", busy, 0);
    check("valid_idle", spikes_valid, 0);
    tick();
    check("busy_idle2", busy, 0);
    check("idx_idle2", neuron_idx, 0);
    for (int i = 0; i < int'(N); i++) begin
      model_mem[i] = dp_mem(m, i);
      model_spk[i] = dp_spk(m, i);
    end
    last_spikes = exp_vec;
  endtask

  initial begin
    rst_n       = 1'b0;
    start       = 1'b0;
    clear       = 1'b0;
    last_spikes = '0;
    zero_model();

    #12;
    check("rst_idx", neuron_idx, 0);
    check("rst_busy", busy, 0);
    check("rst_valid", spikes_valid, 0);
    check("rst_spikes", spikes, 0);
    check("rst_mem", last_membrane, 0);
    check("rst_spk", was_spike, 0);

    @(negedge clk);
    rst_n = 1'b1;
    do_sweep(0, 4'b0100, -1);
    do_sweep(2, 4'b1001, 2);
    do_sweep(1, 4'b0011, -1);
    do_sweep(0, 4'b0100, -1);

    // Clear at index 1 aborts the sweep without publishing.
    mode  = 2;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("clr_idx0", neuron_idx, 0);
    tick();
    check("clr_idx1", neuron_idx, 1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    zero_model();
    check("clr_busy", busy, 0);
    check("clr_idx", neuron_idx, 0);
    check("clr_valid", spikes_valid, 0);
    check("clr_spikes", spikes, last_spikes);
    check("clr_mem", last_membrane, 0);
    tick();
    check("clr_busy2", busy, 0);
    check("clr_valid2", spikes_valid, 0);

    // Simultaneous start and clear in IDLE stays idle.
    start = 1'b1;
    clear = 1'b1;
    tick();
    start = 1'b0;
    clear = 1'b0;
    check("sc_busy", busy, 0);
    check("sc_idx", neuron_idx, 0);
    tick();
    check("sc_busy2", busy, 0);

    do_sweep(0, 4'b0100, -1);

    // Asynchronous reset at index 2.
    mode  = 2;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("mrst_idx2", neuron_idx, 2);
    #2;
    rst_n = 1'b0;
    #1;
    zero_model();
    last_spikes = '0;
    check("mrst_idx", neuron_idx, 0);
    check("mrst_busy", busy, 0);
    check("mrst_valid", spikes_valid, 0);
    check("mrst_spikes", spikes, 0);
    check("mrst_mem", last_membrane, 0);
    check("mrst_spk", was_spike, 0);
    @(negedge clk);
    rst_n = 1'b1;
    do_sweep(2, 4'b1001, -1);

`ifdef NEURON_SPIKE_COUNT_EN
    clear = 1'b1;
    tick();
    clear = 1'b0;
    zero_model();
    check("cnt_clear", spike_count, 0);
    for (int s = 0; s < 3; s++) do_sweep(1, 4'b0011, -1);
    check("cnt_6", spike_count, 6);
    for (int s = 3; s < 200; s++) do_sweep(1, 4'b0011, -1);
    check("cnt_sat", spike_count, 255);
`endif

    tick();
    check("sb_pulses", n_seen, n_pushed);
    check("sb_empty", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/neuron_scheduler.md
NEURON_SCHEDULER -- requirements
Module: neuron_scheduler

Interface
REQ-001 Parameter N_NEURONS, default 4, number of time-multiplexed neurons (power of 2, >=2).
REQ-002 Parameter N_MEMBRANE, default 5, signed membrane width.
REQ-003 Port clk  in  1  sole clock, rising edge.
REQ-004 Port rst_n  in  1  asynchronous, active-low reset.
REQ-005 Port start  in  1  request one timestep sweep over all neurons.
REQ-006 Port clear  in  1  synchronous wipe of all stored neuron state.
REQ-007 Port neuron_idx  out  log2(N_NEURONS)  index of neuron under evaluation, drives weight/threshold select.
REQ-008 Port last_membrane  out  N_MEMBRANE signed  stored membrane of neuron_idx, feeds neuron datapath.
REQ-009 Port was_spike  out  1  stored spike flag of neuron_idx.
REQ-010 Port new_membrane  in  N_MEMBRANE signed  datapath result for neuron_idx, same cycle.
REQ-011 Port is_spike  in  1  datapath spike result for neuron_idx, same cycle.
REQ-012 Port spikes  out  N_NEURONS  spike vector of last completed sweep, bit k = neuron k.
REQ-013 Port spikes_valid  out  1  one-cycle pulse when spikes updates.
REQ-014 Port busy  out  1  high while state != IDLE.

Function
REQ-015 FSM states IDLE, EVAL, DONE; IDLE->EVAL on start (clear low); EVAL->DONE after index N_NEURONS-1; DONE->IDLE unconditionally.
REQ-016 On IDLE->EVAL, neuron_idx SHALL load 0; in EVAL it increments by 1 per cycle, no wrap inside a sweep.
REQ-017 In IDLE/DONE neuron_idx SHALL hold 0.
REQ-018 last_membrane/was_spike SHALL be combinational reads of entry neuron_idx (zero-latency, datapath settles in-cycle).
REQ-019 Each EVAL cycle, at the clock edge, entry neuron_idx SHALL capture new_membrane and is_spike unmodified (no arithmetic, full signed range incl. most-negative value).
REQ-020 Sweep spike bits accumulate in a shadow vector; on EVAL->DONE edge spikes SHALL load the shadow and spikes_valid SHALL be high during DONE only.
REQ-021 Latency: start sampled at edge 0 -> spikes_valid high in cycle N_NEURONS+1, busy high N_NEURONS+1 cycles.
REQ-022 start while busy SHALL be ignored (not queued).
REQ-023 clear SHALL have priority over start and over EVAL writes: all entries -> membrane 0, spike 0, shadow 0, state -> IDLE, no spikes_valid; spikes output retains last published value.
REQ-024 start and clear same cycle in IDLE: clear wins, stays IDLE.

Reset
REQ-025 rst_n low SHALL immediately force: state IDLE, neuron_idx 0, all membranes 0, all stored spike flags 0, shadow 0, spikes 0, spikes_valid 0, busy 0; applies mid-sweep too.
REQ-026 First start after rst_n release SHALL be accepted in the first IDLE cycle.

Configuration
REQ-027 Macro NEURON_SPIKE_COUNT_EN: when defined, add port spike_count out 8 unsigned, incremented on each EVAL edge with is_spike=1, saturating at 255, zeroed by reset and clear.
REQ-028 Without NEURON_SPIKE_COUNT_EN, port spike_count and its counter SHALL not exist; all other behaviour identical.

Structure
REQ-029 Shared package neuron_pkg SHALL hold the FSM state enum and default width constants (N_NEURONS, N_MEMBRANE).
REQ-030 Per-neuron membrane/spike storage SHALL be sub-module membrane_state_bank (one write port, one async read port, sync clear, async reset).

Verification
REQ-031 Sweep: N=4, model returns new_membrane=idx+1, is_spike=(idx==2) -> spikes=4'b0100, spikes_valid pulse in cycle 5; next sweep last_membrane reads 1,2,3,4, was_spike 0,0,1,0.
REQ-032 Busy start: second start pulsed at cycle 2 of sweep -> exactly one spikes_valid, neuron_idx sequence 0,1,2,3 once.
REQ-033 Clear mid-sweep at idx=1 -> busy falls next cycle, no spikes_valid, spikes unchanged, next sweep last_membrane all 0.
REQ-034 Extremes: store -16 (5'b10000) and +15 -> read back -16 and +15 exactly.
REQ-035 Reset mid-sweep at idx=2 -> all outputs 0 asynchronously, first post-reset start runs a full 4-cycle sweep.
REQ-036 NEURON_SPIKE_COUNT_EN: 3 sweeps with 2 spikes each -> spike_count=6; 200 sweeps with 2 spikes -> spike_count=255.
